// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single data-memory port between the pipeline MEM stage (CPU)
//   and the debug unit (DBG loader/dumper). The CPU has priority. DBG is served
//   in these cases:
//     - the CPU is idle;
//     - the pipeline is halted;
//     - DBG has waited MAX_WAIT cycles, which forces one DBG slot.
//   The memory has a registered read, so read data arrives one cycle after
//   the grant.
//
//   Optional feature macro: DMEM_ARB_STATS_EN. It adds saturating grant and
//   forced-slot counters.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cpu_req/we/addr/size/wdata CPU access request (size passes to memory)
//   o_cpu_stall                  CPU request not served this cycle
//   o_cpu_rdata                  memory read data pass-through to the CPU
//   i_dbg_halt                   pipeline halted, DBG gets absolute priority
//   i_dbg_req/we/addr/wdata      DBG request, held until o_dbg_gnt
//   o_dbg_gnt                    DBG request accepted this cycle
//   o_dbg_rvalid, o_dbg_rdata    DBG read data, one cycle after read grant
//   o_mem_*                      to data_memory
//   i_mem_rdata                  from data_memory
//   o_cpu_grants/o_dbg_grants/o_forced   statistics (DMEM_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32,
    parameter int MAX_WAIT    = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cpu_req,
    input  logic                   i_cpu_we,
    input  logic [ADDR_LENGTH-1:0] i_cpu_addr,
    input  logic [4:0]             i_cpu_size,
    input  logic [DATA_LENGTH-1:0] i_cpu_wdata,
    output logic                   o_cpu_stall,
    output logic [DATA_LENGTH-1:0] o_cpu_rdata,
    input  logic                   i_dbg_halt,
    input  logic                   i_dbg_req,
    input  logic                   i_dbg_we,
    input  logic [ADDR_LENGTH-1:0] i_dbg_addr,
    input  logic [DATA_LENGTH-1:0] i_dbg_wdata,
    output logic                   o_dbg_gnt,
    output logic                   o_dbg_rvalid,
    output logic [DATA_LENGTH-1:0] o_dbg_rdata,
    output logic [ADDR_LENGTH-1:0] o_mem_addr,
    output logic                   o_mem_we,
    output logic                   o_mem_re,
    output logic [4:0]             o_mem_size,
    output logic [DATA_LENGTH-1:0] o_mem_wdata,
    input  logic [DATA_LENGTH-1:0] i_mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,output logic [CNT_WIDTH-1:0]   o_cpu_grants,
    output logic [CNT_WIDTH-1:0]   o_dbg_grants,
    output logic [CNT_WIDTH-1:0]   o_forced
`endif
);

    localparam logic [7:0] MAX_W = MAX_WAIT[7:0];

    typedef enum logic [1:0] {S_IDLE, S_CPU, S_DBG, S_DBGF} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t;

    typedef struct packed {
        logic                   we;
        logic                   re;
        logic [ADDR_LENGTH-1:0] addr;
        logic [4:0]             size;
        logic [DATA_LENGTH-1:0] wdata;
    } mem_req_t;

    state_t   state, state_nxt;
    owner_t   owner;
    logic     force_slot;
    logic     forced;
    logic [7:0] wait_cnt;
    logic     rvalid_q;
    mem_req_t mreq;

    // Owner selection and next state. A forced slot is never followed by another
    // forced slot, because force_slot is masked in S_DBGF. A requesting CPU
    // therefore wins the slot after a forced one, unless the pipeline is halted.
    always_comb begin
        force_slot = (wait_cnt == MAX_W) && (state != S_DBGF);
        owner      = OWN_NONE;
        forced     = 1'b0;
        if (!i_rst) begin
            if (i_dbg_req && (i_dbg_halt || !i_cpu_req || force_slot)) begin
                owner  = OWN_DBG;
                // DBG only beats a requesting, un-halted CPU through the force path.
                forced = i_cpu_req && !i_dbg_halt;
            end else if (i_cpu_req) begin
                owner = OWN_CPU;
            end
        end
        case (owner)
            OWN_CPU: state_nxt = S_CPU;
            OWN_DBG: state_nxt = forced ? S_DBGF : S_DBG;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
            rvalid_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (owner == OWN_DBG)
                wait_cnt <= 8'd0;
            else if (i_dbg_req && wait_cnt != MAX_W)
                wait_cnt <= wait_cnt + 8'd1;
            rvalid_q <= (owner == OWN_DBG) && !i_dbg_we;
        end
    end

    // Memory port mux. DBG accesses are always full word (size 0).
    always_comb begin
        mreq = '0;
        case (owner)
            OWN_CPU: begin
                mreq.we    = i_cpu_we;
                mreq.re    = !i_cpu_we;
                mreq.addr  = i_cpu_addr;
                mreq.size  = i_cpu_size;
                mreq.wdata = i_cpu_wdata;
            end
            OWN_DBG: begin
                mreq.we    = i_dbg_we;
                mreq.re    = !i_dbg_we;
                mreq.addr  = i_dbg_addr;
                mreq.wdata = i_dbg_wdata;
            end
            default: ;
        endcase
    end

    assign o_mem_we    = mreq.we;
    assign o_mem_re    = mreq.re;
    assign o_mem_addr  = mreq.addr;
    assign o_mem_size  = mreq.size;
    assign o_mem_wdata = mreq.wdata;

    assign o_cpu_stall = i_cpu_req && (owner != OWN_CPU);
    assign o_cpu_rdata = i_mem_rdata;
    assign o_dbg_gnt   = (owner == OWN_DBG);

    // rvalid is masked by reset so that a reset arriving in the cycle after a
    // read grant drops the response immediately, not one cycle later.
    assign o_dbg_rvalid = rvalid_q && !i_rst;
    assign o_dbg_rdata  = o_dbg_rvalid ? i_mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    logic [CNT_WIDTH-1:0] cpu_cnt, dbg_cnt, frc_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cpu_cnt <= '0;
            dbg_cnt <= '0;
            frc_cnt <= '0;
        end else begin
            if (owner == OWN_CPU && cpu_cnt != '1) cpu_cnt <= cpu_cnt + CNT_ONE;
            if (owner == OWN_DBG && dbg_cnt != '1) dbg_cnt <= dbg_cnt + CNT_ONE;
            if (forced && frc_cnt != '1)           frc_cnt <= frc_cnt + CNT_ONE;
        end
    end

    assign o_cpu_grants = cpu_cnt;
    assign o_dbg_grants = dbg_cnt;
    assign o_forced     = frc_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_cpu_req = 1'b0, i_cpu_we = 1'b0;
    logic [31:0] i_cpu_addr = '0;
    logic [4:0]  i_cpu_size = '0;
    logic [31:0] i_cpu_wdata = '0;
    logic        o_cpu_stall;
    logic [31:0] o_cpu_rdata;
    logic        i_dbg_halt = 1'b0, i_dbg_req = 1'b0, i_dbg_we = 1'b0;
    logic [31:0] i_dbg_addr = '0, i_dbg_wdata = '0;
    logic        o_dbg_gnt, o_dbg_rvalid;
    logic [31:0] o_dbg_rdata;
    logic [31:0] o_mem_addr;
    logic        o_mem_we, o_mem_re;
    logic [4:0]  o_mem_size;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] o_cpu_grants, o_dbg_grants, o_forced;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];
    logic [31:0] mem[256];

    dmem_arbiter #(.ADDR_LENGTH(32), .DATA_LENGTH(32), .MAX_WAIT(8), .CNT_WIDTH(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
        .i_cpu_size(i_cpu_size), .i_cpu_wdata(i_cpu_wdata),
        .o_cpu_stall(o_cpu_stall), .o_cpu_rdata(o_cpu_rdata),
        .i_dbg_halt(i_dbg_halt), .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we),
        .i_dbg_addr(i_dbg_addr), .i_dbg_wdata(i_dbg_wdata),
        .o_dbg_gnt(o_dbg_gnt), .o_dbg_rvalid(o_dbg_rvalid), .o_dbg_rdata(o_dbg_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_re(o_mem_re),
        .o_mem_size(o_mem_size), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
`ifdef DMEM_ARB_STATS_EN
       ,.o_cpu_grants(o_cpu_grants), .o_dbg_grants(o_dbg_grants), .o_forced(o_forced)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Data memory model: registered read on posedge, write on negedge.
    always @(posedge i_clk) if (o_mem_re === 1'b1) i_mem_rdata <= mem[o_mem_addr[7:0]];
    always @(negedge i_clk) if (o_mem_we === 1'b1) mem[o_mem_addr[7:0]] <= o_mem_wdata;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: every DBG read response is matched against the queue.
    always @(negedge i_clk) begin
        if (o_dbg_rvalid === 1'b1) begin
            if (sb.size() == 0) chk("rvalid_unexpected", 32'(o_dbg_rvalid), 32'd0);
            else                chk("dbg_rdata", o_dbg_rdata, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_all();
        i_cpu_req = 1'b0; i_dbg_req = 1'b0; i_dbg_halt = 1'b0;
    endtask

    // CPU requests every cycle while DBG holds a read: the 9th cycle must be
    // the forced DBG slot, and the CPU must win the slot right after it.
    task automatic force_seq(input string tag, input logic [31:0] exp_data);
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 32'h80; i_cpu_size = 5'b10000;
        i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 32'd8;
        sb.push_back(exp_data);
        for (int i = 1; i <= 9; i++) begin
            #3;
            chk($sformatf("%s_gnt%0d", tag, i), 32'(o_dbg_gnt), 32'(i == 9));
            chk($sformatf("%s_stall%0d", tag, i), 32'(o_cpu_stall), 32'(i == 9));
            if (i == 9) chk($sformatf("%s_size", tag), 32'(o_mem_size), 32'd0);
            tick();
        end
        i_dbg_we = 1'b1; i_dbg_addr = 32'h40; i_dbg_wdata = 32'h55;
        #3;
        chk($sformatf("%s_after_gnt", tag), 32'(o_dbg_gnt), 32'd0);
        chk($sformatf("%s_after_stall", tag), 32'(o_cpu_stall), 32'd0);
        tick();
        idle_all();
        tick();
    endtask

    initial begin
        int gcnt;
        for (int k = 0; k < 256; k++) mem[k] = 32'd0;
        mem[8] = 32'hDEADBEEF;

        // T1: reset held with both requests active.
        i_cpu_req = 1'b1; i_dbg_req = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("rst_we", 32'(o_mem_we), 32'd0);
            chk("rst_re", 32'(o_mem_re), 32'd0);
            chk("rst_gnt", 32'(o_dbg_gnt), 32'd0);
            chk("rst_stall", 32'(o_cpu_stall), 32'd1);
            chk("rst_rvalid", 32'(o_dbg_rvalid), 32'd0);
            tick();
        end
        i_rst = 1'b0; idle_all();
        #3;
        chk("post_rst_stall", 32'(o_cpu_stall), 32'd0);
        chk("post_rst_rvalid", 32'(o_dbg_rvalid), 32'd0);
        tick();

        // T2: CPU byte write, no DBG.
        i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 32'd4;
        i_cpu_size = 5'b00001; i_cpu_wdata = 32'hA5;
        #3;
        chk("t2_stall", 32'(o_cpu_stall), 32'd0);
        chk("t2_we", 32'(o_mem_we), 32'd1);
        chk("t2_re", 32'(o_mem_re), 32'd0);
        chk("t2_size", 32'(o_mem_size), 32'd1);
        chk("t2_addr", o_mem_addr, 32'd4);
        chk("t2_wdata", o_mem_wdata, 32'hA5);
        tick();
        // CPU read back: data arrives one cycle after grant.
        i_cpu_we = 1'b0; i_cpu_size = 5'b10000;
        #3;
        chk("t2_rd_re", 32'(o_mem_re), 32'd1);
        tick();
        i_cpu_req = 1'b0;
        #3;
        chk("t2_cpu_rdata", o_cpu_rdata, 32'hA5);
        chk("t2_dbg_rdata_zero", o_dbg_rdata, 32'd0);
        tick();

        // T3: DBG read while CPU idle.
        i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 32'd8;
        sb.push_back(32'hDEADBEEF);
        #3;
        chk("t3_gnt", 32'(o_dbg_gnt), 32'd1);
        chk("t3_re", 32'(o_mem_re), 32'd1);
        chk("t3_addr", o_mem_addr, 32'd8);
        chk("t3_size", 32'(o_mem_size), 32'd0);
        tick();
        i_dbg_req = 1'b0;
        #3;
        chk("t3_rvalid", 32'(o_dbg_rvalid), 32'd1);
        tick();
        #3;
        chk("t3_rvalid_drop", 32'(o_dbg_rvalid), 32'd0);
        tick();

        // T4: anti-starvation forced slot.
        force_seq("t4", 32'hDEADBEEF);

        // T5: halted pipeline, 16 back-to-back DBG writes then reads.
        i_dbg_halt = 1'b1; i_cpu_req = 1'b1; i_cpu_we = 1'b0;
        gcnt = 0;
        for (int a = 0; a < 16; a++) begin
            i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 32'(a); i_dbg_wdata = 32'h100 + 32'(a);
            #3;
            if (o_dbg_gnt) gcnt++;
            chk($sformatf("t5_stall%0d", a), 32'(o_cpu_stall), 32'd1);
            tick();
        end
        chk("t5_gnts", 32'(gcnt), 32'd16);
        for (int a = 0; a < 16; a++) begin
            i_dbg_we = 1'b0; i_dbg_addr = 32'(a);
            sb.push_back(32'h100 + 32'(a));
            #3;
            chk($sformatf("t5_rgnt%0d", a), 32'(o_dbg_gnt), 32'd1);
            if (a > 0) chk($sformatf("t5_rvalid%0d", a), 32'(o_dbg_rvalid), 32'd1);
            tick();
        end
        idle_all();
        #3;
        chk("t5_rvalid_last", 32'(o_dbg_rvalid), 32'd1);
        tick();

        // T6: reset in the cycle after a DBG read grant drops rvalid.
        i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 32'd3;
        #3;
        chk("t6_gnt", 32'(o_dbg_gnt), 32'd1);
        tick();
        i_rst = 1'b1; i_dbg_req = 1'b0;
        #3;
        chk("t6_rvalid_rst", 32'(o_dbg_rvalid), 32'd0);
        tick();
        i_rst = 1'b0;
        #3;
        chk("t6_rvalid_after", 32'(o_dbg_rvalid), 32'd0);
        tick();

        // T7: wait counter built up, then cleared by reset.
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 32'h40;
        for (int i = 0; i < 5; i++) begin
            #3;
            chk($sformatf("t7_wait_gnt%0d", i), 32'(o_dbg_gnt), 32'd0);
            tick();
        end
        idle_all(); i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        force_seq("t7", 32'h108);

        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
